// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: data-memory bus between the load/store unit (master) and memory (slave).
interface riscv_lsu_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );
    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit running a registered request/ready memory transaction,
// stalling the core until completion and returning extended load data.
module riscv_lsu (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [2:0]         core_size_i,
    input  logic [31:0]        core_addr_i,
    input  logic [31:0]        core_wd_i,
    output logic [31:0]        core_rd_o,
    output logic               core_stall_o,
    output logic               lsu_err_o,
    riscv_lsu_if.master        mem
);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d, wd_q, wd_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        busy, size_ok, is_h, is_w, err;
    logic [3:0]  be_new;
    logic [31:0] wd_new, fmt;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign busy    = state_q == BUSY;
    assign size_ok = core_size_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign is_h    = core_size_i[1:0] == 2'b01;
    assign is_w    = core_size_i == 3'b010;
    assign err     = !busy && core_req_i &&
                     (!size_ok || (is_h && core_addr_i[0]) || (is_w && core_addr_i[1:0] != 2'b00));
    assign be_new  = core_size_i[1:0] == 2'b00 ? 4'b0001 << core_addr_i[1:0] :
                     core_size_i[1:0] == 2'b01 ? (core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd_new  = core_size_i[1:0] == 2'b00 ? {4{core_wd_i[7:0]}} :
                     core_size_i[1:0] == 2'b01 ? {2{core_wd_i[15:0]}} : core_wd_i;

    // size_q[2] marks the unsigned variants, so it suppresses sign extension
    assign lane_b  = mem.mem_rd_i[{off_q, 3'b000} +: 8];
    assign lane_h  = off_q[1] ? mem.mem_rd_i[31:16] : mem.mem_rd_i[15:0];
    assign fmt     = size_q[1:0] == 2'b00 ? {{24{~size_q[2] & lane_b[7]}}, lane_b} :
                     size_q[1:0] == 2'b01 ? {{16{~size_q[2] & lane_h[15]}}, lane_h} : mem.mem_rd_i;

    assign lsu_err_o = err;
    assign core_rd_o = (busy && mem.mem_ready_i && !we_q) ? fmt : 32'h0;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        size_d       = size_q;
        off_d        = off_q;
        core_stall_o = 1'b0;
        if (busy) begin
            core_stall_o = !mem.mem_ready_i;
            if (mem.mem_ready_i) begin
                req_d   = 1'b0;
                be_d    = 4'b0000;
                state_d = IDLE;
            end
        end else if (core_req_i && !err) begin
            core_stall_o = 1'b1;
            req_d        = 1'b1;
            we_d         = core_we_i;
            be_d         = be_new;
            addr_d       = {core_addr_i[31:2], 2'b00};
            wd_d         = wd_new;
            size_d       = core_size_i;
            off_d        = core_addr_i[1:0];
            state_d      = BUSY;
        end
        core_stall_o = core_stall_o & rst_ni;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0;
            wd_q    <= 32'h0;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            size_q  <= size_d;
            off_q   <= off_d;
        end
    end

    assign mem.mem_req_o  = req_q;
    assign mem.mem_we_o   = we_q;
    assign mem.mem_be_o   = be_q;
    assign mem.mem_addr_o = addr_q;
    assign mem.mem_wd_o   = wd_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scoreboard-driven checks of riscv_lsu loads, stores, wait states, errors and reset.
module tb_riscv_lsu;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, core_rd_o;
    logic        core_stall_o, lsu_err_o;
    int          n_cmp = 0;
    int          n_bad = 0;

    riscv_lsu_if bus();

    riscv_lsu dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .lsu_err_o(lsu_err_o), .mem(bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          stalls;
    } txn_t;

    typedef struct {
        logic        we, req, err, stable, stall_done, req_after;
        logic [31:0] addr, wd, rd;
        logic [3:0]  be, be_after;
        int          stalls;
    } obs_t;

    txn_t sb[$];

    // Drives one accepted access and records what the DUT showed; comparisons live in the tests.
    task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                              output obs_t o);
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = we; core_size_i = size; core_addr_i = addr; core_wd_i = wd;
        bus.mem_ready_i = 1'b0; bus.mem_rd_i = 32'h0;
        #1;
        o.stalls = core_stall_o ? 1 : 0;
        o.err = lsu_err_o;
        @(posedge clk_i); #1;
        o.req = bus.mem_req_o; o.we = bus.mem_we_o; o.be = bus.mem_be_o;
        o.addr = bus.mem_addr_o; o.wd = bus.mem_wd_o; o.stable = 1'b1;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk_i); #1;
            if (core_stall_o) o.stalls++;
            if (bus.mem_req_o !== o.req || bus.mem_we_o !== o.we || bus.mem_be_o !== o.be ||
                bus.mem_addr_o !== o.addr || bus.mem_wd_o !== o.wd) o.stable = 1'b0;
        end
        @(negedge clk_i);
        bus.mem_ready_i = 1'b1; bus.mem_rd_i = rdata;
        #1;
        o.stall_done = core_stall_o; o.rd = core_rd_o;
        @(posedge clk_i); #1;
        o.req_after = bus.mem_req_o; o.be_after = bus.mem_be_o;
        bus.mem_ready_i = 1'b0;
    endtask

    task automatic go_idle;
        @(negedge clk_i);
        core_req_i = 1'b0; bus.mem_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b010;
        core_addr_i = 32'h100; core_wd_i = 32'hFFFF_FFFF; bus.mem_ready_i = 1'b1; bus.mem_rd_i = 32'h0;
        #12;
        n_cmp++; if (core_stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", core_stall_o); end
        n_cmp++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o} !== 6'b0) begin n_bad++; $display("FAIL reset_ctl got %b want 000000", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}); end
        n_cmp++; if ({bus.mem_addr_o, bus.mem_wd_o} !== 64'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", {bus.mem_addr_o, bus.mem_wd_o}); end
        @(negedge clk_i);
        rst_ni = 1'b1; core_req_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++; if (bus.mem_req_o !== 1'b0 || core_stall_o !== 1'b0) begin n_bad++; $display("FAIL idle_ready_ignored got req=%b stall=%b want 0/0", bus.mem_req_o, core_stall_o); end
        go_idle();
    endtask

    task automatic test_word_load;
        obs_t o; txn_t e;
        sb.push_back('{we: 1'b0, addr: 32'h104, be: 4'b1111, wd: 32'h0, rd: 32'hDEAD_BEEF, stalls: 1});
        run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 0, o);
        e = sb.pop_front();
        n_cmp++; if (o.err !== 1'b0) begin n_bad++; $display("FAIL wl_err got %b want 0", o.err); end
        n_cmp++; if (o.req !== 1'b1) begin n_bad++; $display("FAIL wl_req got %b want 1", o.req); end
        n_cmp++; if (o.we !== e.we) begin n_bad++; $display("FAIL wl_we got %b want %b", o.we, e.we); end
        n_cmp++; if (o.addr !== e.addr) begin n_bad++; $display("FAIL wl_addr got %h want %h", o.addr, e.addr); end
        n_cmp++; if (o.be !== e.be) begin n_bad++; $display("FAIL wl_be got %b want %b", o.be, e.be); end
        n_cmp++; if (o.stalls !== e.stalls) begin n_bad++; $display("FAIL wl_stalls got %0d want %0d", o.stalls, e.stalls); end
        n_cmp++; if (o.stall_done !== 1'b0) begin n_bad++; $display("FAIL wl_stall_done got %b want 0", o.stall_done); end
        n_cmp++; if (o.rd !== e.rd) begin n_bad++; $display("FAIL wl_rd got %h want %h", o.rd, e.rd); end
        n_cmp++; if (o.req_after !== 1'b0 || o.be_after !== 4'b0) begin n_bad++; $display("FAIL wl_release got req=%b be=%b want 0/0000", o.req_after, o.be_after); end
        go_idle();
    endtask

    task automatic test_byte_loads;
        obs_t o; txn_t e;
        logic [2:0]  sz[3]  = '{3'b000, 3'b100, 3'b101};
        logic [31:0] ad[3]  = '{32'h103, 32'h103, 32'h102};
        sb.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1000, wd: 32'h0, rd: 32'hFFFF_FF80, stalls: 1});
        sb.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1000, wd: 32'h0, rd: 32'h0000_0080, stalls: 1});
        sb.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1100, wd: 32'h0, rd: 32'h0000_80FF, stalls: 1});
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, sz[i], ad[i], 32'h0, 32'h80FF_0000, 0, o);
            e = sb.pop_front();
            n_cmp++; if (o.rd !== e.rd) begin n_bad++; $display("FAIL bl_rd[%0d] got %h want %h", i, o.rd, e.rd); end
            n_cmp++; if (o.be !== e.be || o.addr !== e.addr) begin n_bad++; $display("FAIL bl_bus[%0d] got be=%b addr=%h want be=%b addr=%h", i, o.be, o.addr, e.be, e.addr); end
        end
        go_idle();
    endtask

    task automatic test_half_store;
        obs_t o; txn_t e;
        sb.push_back('{we: 1'b1, addr: 32'h204, be: 4'b1100, wd: 32'hABCD_ABCD, rd: 32'h0, stalls: 1});
        run_access(1'b1, 3'b001, 32'h206, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, o);
        e = sb.pop_front();
        n_cmp++; if (o.we !== e.we) begin n_bad++; $display("FAIL hs_we got %b want %b", o.we, e.we); end
        n_cmp++; if (o.be !== e.be) begin n_bad++; $display("FAIL hs_be got %b want %b", o.be, e.be); end
        n_cmp++; if (o.wd !== e.wd) begin n_bad++; $display("FAIL hs_wd got %h want %h", o.wd, e.wd); end
        n_cmp++; if (o.addr !== e.addr) begin n_bad++; $display("FAIL hs_addr got %h want %h", o.addr, e.addr); end
        n_cmp++; if (o.rd !== e.rd) begin n_bad++; $display("FAIL hs_rd got %h want %h", o.rd, e.rd); end
        go_idle();
    endtask

    task automatic test_wait_states;
        obs_t o; txn_t e;
        sb.push_back('{we: 1'b0, addr: 32'h40, be: 4'b1111, wd: 32'h0, rd: 32'h0123_4567, stalls: 4});
        run_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h0123_4567, 3, o);
        e = sb.pop_front();
        n_cmp++; if (o.stalls !== e.stalls) begin n_bad++; $display("FAIL ws_stalls got %0d want %0d", o.stalls, e.stalls); end
        n_cmp++; if (o.stable !== 1'b1) begin n_bad++; $display("FAIL ws_stable got %b want 1", o.stable); end
        n_cmp++; if (o.rd !== e.rd || o.stall_done !== 1'b0) begin n_bad++; $display("FAIL ws_done got rd=%h stall=%b want %h/0", o.rd, o.stall_done, e.rd); end
        go_idle();
    endtask

    task automatic test_errors;
        logic [2:0]  sz[3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] ad[3] = '{32'h102, 32'h101, 32'h100};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = sz[i]; core_addr_i = ad[i];
            #1;
            n_cmp++; if (lsu_err_o !== 1'b1 || core_stall_o !== 1'b0) begin n_bad++; $display("FAIL err[%0d] got err=%b stall=%b want 1/0", i, lsu_err_o, core_stall_o); end
            @(posedge clk_i); #1;
            n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL err_req[%0d] got %b want 0", i, bus.mem_req_o); end
        end
        go_idle();
    endtask

    task automatic test_reset_busy;
        obs_t o; txn_t e;
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h10; bus.mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++; if (bus.mem_req_o !== 1'b1) begin n_bad++; $display("FAIL rb_busy got %b want 1", bus.mem_req_o); end
        @(negedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req_o !== 1'b0 || bus.mem_be_o !== 4'b0 || core_stall_o !== 1'b0) begin n_bad++; $display("FAIL rb_async got req=%b be=%b stall=%b want 0/0000/0", bus.mem_req_o, bus.mem_be_o, core_stall_o); end
        @(negedge clk_i);
        rst_ni = 1'b1; core_req_i = 1'b0;
        sb.push_back('{we: 1'b1, addr: 32'h300, be: 4'b0010, wd: 32'h5A5A_5A5A, rd: 32'h0, stalls: 1});
        run_access(1'b1, 3'b000, 32'h301, 32'h0000_005A, 32'h0, 0, o);
        e = sb.pop_front();
        n_cmp++; if (o.be !== e.be || o.wd !== e.wd || o.addr !== e.addr) begin n_bad++; $display("FAIL rb_sb got be=%b wd=%h addr=%h want be=%b wd=%h addr=%h", o.be, o.wd, o.addr, e.be, e.wd, e.addr); end
        n_cmp++; if (o.stalls !== e.stalls || o.req_after !== 1'b0) begin n_bad++; $display("FAIL rb_sb_done got stalls=%0d req=%b want %0d/0", o.stalls, o.req_after, e.stalls); end
        go_idle();
    endtask

    task automatic test_back_to_back;
        obs_t o; txn_t e;
        logic [2:0]  sz[3] = '{3'b010, 3'b001, 3'b100};
        logic [31:0] ad[3] = '{32'h8, 32'hA, 32'h9};
        logic [31:0] rv[3] = '{32'hCAFE_F00D, 32'h8001_1234, 32'h0000_C300};
        sb.push_back('{we: 1'b0, addr: 32'h8, be: 4'b1111, wd: 32'h0, rd: 32'hCAFE_F00D, stalls: 1});
        sb.push_back('{we: 1'b0, addr: 32'h8, be: 4'b1100, wd: 32'h0, rd: 32'hFFFF_8001, stalls: 1});
        sb.push_back('{we: 1'b0, addr: 32'h8, be: 4'b0010, wd: 32'h0, rd: 32'h0000_00C3, stalls: 1});
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, sz[i], ad[i], 32'h0, rv[i], 0, o);
            e = sb.pop_front();
            n_cmp++; if (o.req !== 1'b1 || o.stalls !== e.stalls) begin n_bad++; $display("FAIL b2b_accept[%0d] got req=%b stalls=%0d want 1/%0d", i, o.req, o.stalls, e.stalls); end
            n_cmp++; if (o.rd !== e.rd || o.be !== e.be) begin n_bad++; $display("FAIL b2b_rd[%0d] got rd=%h be=%b want rd=%h be=%b", i, o.rd, o.be, e.rd, e.be); end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_loads();
        test_half_store();
        test_wait_states();
        test_errors();
        test_reset_busy();
        test_back_to_back();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
